// File: rtl/package_arrays.sv
// Shared array/word types used by the packet datapath blocks.
package package_arrays;

    typedef logic [31:0] t_data32;

endpackage

// File: rtl/package_ipv6.sv
// IPv6 fixed-header layout; the first field sits in the most significant bits, so Version is bits 319:316.
package package_ipv6;

    localparam int IPV6_HEADER_WORDS = 10;

    typedef struct packed {
        logic [3:0]   version;
        logic [7:0]   traffic_class;
        logic [19:0]  flow_label;
        logic [15:0]  payload_length;
        logic [7:0]   next_header;
        logic [7:0]   hop_limit;
        logic [127:0] source_address;
        logic [127:0] destination_address;
    } t_ipv6_header;

endpackage

// File: rtl/ipv6_header_serializer.sv
// Serializes a 320-bit IPv6 header into ten 32-bit words with valid/ready on both sides.
// Optional build macro IPV6_SERIALIZER_VERSION_CHECK_EN drops headers whose Version is not 6 and pulses o_err.
//
// state | meaning
// IDLE  | no header held, ready to accept
// SEND  | emitting words of the captured header
module ipv6_header_serializer
    import package_ipv6::*;
    import package_arrays::*;
#(
    parameter int ORDER = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  t_ipv6_header i_head,
    output logic         o_valid,
    input  logic         o_ready,
    output t_data32      o_data,
    output logic         o_last,
    output logic         o_err
);

    localparam int CNT_W = $clog2(IPV6_HEADER_WORDS);
    localparam logic [CNT_W-1:0] FIRST_IDX = CNT_W'((ORDER != 0) ? IPV6_HEADER_WORDS - 1 : 0);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'((ORDER != 0) ? 0 : IPV6_HEADER_WORDS - 1);

    typedef enum logic {IDLE, SEND} t_state;

    t_state           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    t_ipv6_header     head_q;
    logic             in_hs;
    logic             out_hs;
    logic             hdr_bad;
    logic             err_q;

    assign i_ready = (state == IDLE) | (o_valid & o_ready & o_last);
    assign in_hs   = i_valid & i_ready;
    assign out_hs  = o_valid & o_ready;
    assign o_data  = head_q[32*cnt +: 32];

    assign cnt_next = (ORDER != 0) ? cnt - CNT_W'(1) : cnt + CNT_W'(1);

`ifdef IPV6_SERIALIZER_VERSION_CHECK_EN
    assign hdr_bad = (i_head.version != 4'd6);
    assign o_err   = err_q;
`else
    assign hdr_bad = 1'b0;
    assign o_err   = 1'b0;
`endif

    // A new header accepted alongside the last-word handshake takes priority, keeping o_valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            head_q  <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (in_hs) begin
                head_q <= i_head;
                cnt    <= FIRST_IDX;
                o_last <= 1'b0;
                if (hdr_bad) begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                    err_q   <= 1'b1;
                end else begin
                    state   <= SEND;
                    o_valid <= 1'b1;
                end
            end else if (out_hs) begin
                if (o_last) begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                    o_last  <= 1'b0;
                end else begin
                    cnt    <= cnt_next;
                    o_last <= (cnt_next == LAST_IDX);
                end
            end
        end
    end

endmodule

// File: tb/tb_ipv6_header_serializer.sv
// Directed bench: one ORDER=0 and one ORDER=1 instance driven by the same input stream.
module tb_ipv6_header_serializer;
    import package_ipv6::*;
    import package_arrays::*;

    logic         clk;
    logic         rst;
    logic         i_valid;
    logic         o_ready;
    t_ipv6_header i_head;
    logic         i_ready0, i_ready1;
    logic         o_valid0, o_valid1;
    t_data32      o_data0, o_data1;
    logic         o_last0, o_last1;
    logic         o_err0, o_err1;

    int n_tests = 0;
    int n_fail  = 0;

    ipv6_header_serializer #(.ORDER(0)) dut0 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready0), .i_head(i_head),
        .o_valid(o_valid0), .o_ready(o_ready), .o_data(o_data0), .o_last(o_last0), .o_err(o_err0)
    );

    ipv6_header_serializer #(.ORDER(1)) dut1 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready1), .i_head(i_head),
        .o_valid(o_valid1), .o_ready(o_ready), .o_data(o_data1), .o_last(o_last1), .o_err(o_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // word 0 = dst, word 9 = {ver, 4'h0, seed, 16'h1234}, middle words tagged with seed and index
    function automatic logic [319:0] mk_head(input logic [3:0] ver, input logic [31:0] dst,
                                             input logic [7:0] seed);
        logic [319:0] h;
        h = '0;
        h[31:0] = dst;
        for (int k = 1; k < 9; k++) h[32*k +: 32] = {seed, 8'(k), 16'h5A5A};
        h[319:288] = {ver, 4'h0, seed, 16'h1234};
        return h;
    endfunction

    function automatic logic [31:0] word_of(input logic [319:0] h, input int k);
        return h[32*k +: 32];
    endfunction

    // Precondition: header h accepted at the posedge just before the current negedge.
    task automatic expect_header(input logic [319:0] h, input int stall_word, input int stall_n,
                                 input bit chain, input logic [319:0] next_h);
        for (int k = 0; k < 10; k++) begin
            for (int s = 0; s <= ((k == stall_word) ? stall_n : 0); s++) begin
                o_ready = (k != stall_word) || (s == stall_n);
                #1;
                chk($sformatf("o_valid0 w%0d", k), o_valid0, 1'b1);
                chk($sformatf("o_data0 w%0d", k), o_data0, word_of(h, k));
                chk($sformatf("o_last0 w%0d", k), o_last0, k == 9);
                chk($sformatf("o_data1 w%0d", k), o_data1, word_of(h, 9 - k));
                chk($sformatf("o_last1 w%0d", k), o_last1, k == 9);
                chk($sformatf("i_ready0 w%0d", k), i_ready0, (k == 9) && o_ready);
                chk($sformatf("o_err0 w%0d", k), o_err0, 1'b0);
                if (chain && k == 9 && o_ready) begin
                    i_valid = 1'b1;
                    i_head  = t_ipv6_header'(next_h);
                end else begin
                    i_valid = 1'b0;
                    i_head  = t_ipv6_header'(~h);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic offer(input logic [319:0] h);
        i_valid = 1'b1;
        i_head  = t_ipv6_header'(h);
        o_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        #1;
        chk({tag, " o_valid0"}, o_valid0, 1'b0);
        chk({tag, " o_valid1"}, o_valid1, 1'b0);
        chk({tag, " i_ready0"}, i_ready0, 1'b1);
    endtask

    logic [319:0] h1, h2, h3, h4, h5, h6, h7, h8;

    initial begin
        h1 = mk_head(4'h6, 32'hDEADBEEF, 8'h11);
        h2 = mk_head(4'h6, 32'h01020304, 8'h22);
        h3 = mk_head(4'h6, 32'hCAFEF00D, 8'h33);
        h4 = mk_head(4'h6, 32'h44444444, 8'h44);
        h5 = mk_head(4'h6, 32'h55555555, 8'h55);
        h6 = mk_head(4'h6, 32'h66666666, 8'h66);
        h7 = mk_head(4'h4, 32'h77777777, 8'h77);
        h8 = mk_head(4'h6, 32'h88888888, 8'h88);

        rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0; i_head = '0;
        repeat (2) @(negedge clk);
        chk("rst o_valid", o_valid0, 1'b0);
        chk("rst o_last", o_last0, 1'b0);
        chk("rst o_err", o_err0, 1'b0);
        chk("rst o_data0", o_data0, 32'h0);
        chk("rst o_data1", o_data1, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_idle("post-rst");

        // single header, hand-computed boundary words
        offer(h1);
        #1;
        chk("h1 first word0", o_data0, 32'hDEADBEEF);
        chk("h1 first word1 version", {28'h0, o_data1[31:28]}, 32'h6);
        chk("h1 first word1", o_data1, 32'h6011_1234);
        expect_header(h1, -1, 0, 1'b0, '0);
        check_idle("h1 done");

        // back-to-back, no bubble
        offer(h2);
        i_head = t_ipv6_header'(h3);
        expect_header(h2, -1, 0, 1'b1, h3);
        expect_header(h3, -1, 0, 1'b0, '0);
        check_idle("h3 done");

        // word 3 held for three cycles
        offer(h4);
        expect_header(h4, 3, 2, 1'b0, '0);
        check_idle("h4 done");

        // reset after word 4 handshake aborts the header
        offer(h5);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("h5 w%0d", k), o_data0, word_of(h5, k));
            i_valid = 1'b0;
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("abort o_valid0", o_valid0, 1'b0);
        chk("abort o_last0", o_last0, 1'b0);
        chk("abort o_data0", o_data0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        check_idle("abort rel");
        repeat (2) @(negedge clk);
        check_idle("abort quiet");
        offer(h6);
        expect_header(h6, -1, 0, 1'b0, '0);
        check_idle("h6 done");

        // Version 4 header
        offer(h7);
`ifdef IPV6_SERIALIZER_VERSION_CHECK_EN
        i_valid = 1'b0;
        #1;
        chk("v4 o_err0", o_err0, 1'b1);
        chk("v4 o_err1", o_err1, 1'b1);
        check_idle("v4 drop");
        @(negedge clk);
        chk("v4 o_err clear", o_err0, 1'b0);
        check_idle("v4 after");
`else
        expect_header(h7, -1, 0, 1'b0, '0);
        check_idle("v4 done");
        chk("v4 o_err", o_err0, 1'b0);
`endif
        offer(h8);
        expect_header(h8, 9, 1, 1'b0, '0);
        check_idle("h8 done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ipv6_header_serializer.md
IPV6_HEADER_SERIALIZER -- requirements
Module: ipv6_header_serializer

Interface
REQ-001 The block SHALL have parameter ORDER, default 0; 0 emits word 0 (header bits 31:0) first, 1 emits word 9 (bits 319:288) first.
REQ-002 The block SHALL have one clock and an asynchronous active-high reset: clk  input  1  system clock, rising edge.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 i_valid  input  1  header offered.
REQ-005 i_ready  output  1  header accepted when i_valid & i_ready at clk.
REQ-006 i_head  input  t_ipv6_header (320)  header to transmit.
REQ-007 o_valid  output  1  word offered.
REQ-008 o_ready  input  1  word consumed when o_valid & o_ready at clk.
REQ-009 o_data  output  t_data32 (32)  current word.
REQ-010 o_last  output  1  high with final word of a header.
REQ-011 o_err  output  1  one-cycle pulse on a dropped header (see Configuration).

Function
REQ-012 Word k SHALL be i_head[32*k +: 32], k = 0..9, so output is bit-compatible with the 32-bit header assembler.
REQ-013 The FSM SHALL have states IDLE and SEND; IDLE->SEND on input handshake; SEND->IDLE on output handshake of the last word with no new header accepted in that cycle.
REQ-014 On input handshake, i_head SHALL be captured into an internal 320-bit register and the word counter set to the first index (0 or 9 per ORDER).
REQ-015 o_valid SHALL rise the cycle after the input handshake (latency 1), and o_data SHALL be a mux of the captured register indexed by the counter.
REQ-016 The counter SHALL advance by +1 (ORDER=0) or -1 (ORDER=1) only on an output handshake, and SHALL not wrap within a header.
REQ-017 o_last SHALL equal o_valid & (counter == 9 for ORDER=0, 0 for ORDER=1).
REQ-018 While o_valid & !o_ready, o_data, o_last and o_valid SHALL hold stable.
REQ-019 i_ready SHALL be (state == IDLE) | (o_valid & o_ready & o_last), giving back-to-back headers with no bubble: 10 words per 10 cycles.
REQ-020 A header accepted concurrently with the last-word handshake SHALL start at the first index the next cycle with o_valid kept high.
REQ-021 i_head SHALL be ignored when not handshaken; i_head changes during SEND SHALL not affect output.

Reset
REQ-022 During and after rst: state IDLE, counter 0, header register all-zero, o_valid 0, o_last 0, o_err 0, i_ready 1 after release.
REQ-023 rst asserted mid-header SHALL abort it immediately; no remaining words SHALL be emitted after release.

Configuration
REQ-024 Macro IPV6_SERIALIZER_VERSION_CHECK_EN: when defined, a header with Version != 4'd6 SHALL be accepted (i_ready behaviour unchanged), not emitted, state stays/returns IDLE, and o_err pulses one cycle after acceptance.
REQ-025 When IPV6_SERIALIZER_VERSION_CHECK_EN is not defined, every header SHALL be emitted regardless of Version and o_err SHALL be constant 0.

Structure
REQ-026 t_ipv6_header SHALL come from package_ipv6 and t_data32 from package_arrays; constant IPV6_HEADER_WORDS = 10 SHALL be added to package_ipv6 and used for counter bounds.
REQ-027 The block SHALL be a single module; no sub-module is required.

Verification
REQ-028 Single header, o_ready=1, ORDER=0, Version=6, DestinationAddress[31:0]=32'hDEADBEEF -> o_valid 10 consecutive cycles from cycle after accept, word0=32'hDEADBEEF, o_last only on word 9, word9[31:28]=4'h6.
REQ-029 Two headers back-to-back, o_ready=1 -> 20 consecutive valid words, i_ready high on word 9 cycle, no gap.
REQ-030 o_ready toggling 1,0,0,1 during word 3 -> word 3 held 3 cycles unchanged, total 10 words, order intact.
REQ-031 ORDER=1 -> first word is bits 319:288 (Version first), o_last on bits 31:0.
REQ-032 rst pulsed after word 4 -> o_valid 0 immediately, i_ready 1 after release, next header starts from first word.
REQ-033 With IPV6_SERIALIZER_VERSION_CHECK_EN, Version=4'd4 header -> no o_valid, one o_err pulse; following Version=6 header emitted normally; without macro the same Version=4 header is emitted, o_err stays 0.
